div_sched: RTL and testbench

Round-robin scheduler that shares one iterative 64/32 restoring divider between up to eight requesters. It accepts one request at a time and loads the operands into the divider. It then sequences the divider's reset/run protocol, captures the quotient and remainder on `fin`, and returns them to the owning requester with a one-cycle `done` pulse. It sits between the requesting datapaths and a single `divider` instance.

---
 rtl/div_sched.sv | 174 +++++++++++++++++
 tb/tb_div_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one iterative 64/32 divider
// between NREQ requesters. One operation at a time: grant, run the
// divider through its reset/run protocol, return the result with a
// one-cycle done pulse to the owner.
// Optional build macro DIV_SCHED_DZ_EN: zero divisors bypass the divider
// through a short ZERO state and report dz.
module div_sched #(
  parameter int NREQ = 4,
  parameter int WDOG = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   dvdend_in,
  input  logic [32*NREQ-1:0]   dvsor_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          quot_out,
  output logic [31:0]          rem_out,
  output logic                 ovf,
  output logic                 dz,
  output logic                 err,
  output logic                 busy,
  output logic                 div_reset,
  output logic [63:0]          div_dvdend,
  output logic [31:0]          div_dvsor,
  input  logic                 div_fin,
  input  logic [31:0]          div_quot,
  input  logic [63:0]          div_rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef DIV_SCHED_DZ_EN
    , ZERO = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  owner;
  logic [2:0]  win_idx;
  logic        win_vld;
  logic [63:0] win_dvdend;
  logic [31:0] win_dvsor;
  logic [5:0]  cnt;
  logic        ovf_p;

  // Lower half of the divider remainder register is working state, not a result.
  logic unused_rem_lo;
  assign unused_rem_lo = ^div_rem[31:0];

  // Round-robin pick: first set request after the pointer, wrapping around.
  // Offsets are scanned from the far end so the nearest one wins last.
  always_comb begin
    logic [2:0] c;
    win_vld = 1'b0;
    win_idx = ptr;
    c       = '0;
    for (int o = NREQ; o >= 1; o--) begin
      c = 3'((int'(ptr) + o) % NREQ);
      if (|(req & (NREQ'(1) << c))) begin
        win_vld = 1'b1;
        win_idx = c;
      end
    end
  end

  // Winner's operand slices.
  always_comb begin
    win_dvdend = 64'(dvdend_in >> (64 * int'(win_idx)));
    win_dvsor  = 32'(dvsor_in  >> (32 * int'(win_idx)));
  end

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      quot_out   <= '0;
      rem_out    <= '0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      div_reset  <= 1'b1;
      div_dvdend <= '0;
      div_dvsor  <= '0;
      ptr        <= 3'(NREQ - 1);
      owner      <= '0;
      cnt        <= '0;
      ovf_p      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          div_reset <= 1'b1;
          if (win_vld) begin
            div_dvdend <= win_dvdend;
            div_dvsor  <= win_dvsor;
            gnt        <= NREQ'(1) << win_idx;
            owner      <= win_idx;
            ptr        <= win_idx;
            ovf_p      <= (win_dvdend[63:32] >= win_dvsor);
            cnt        <= '0;
            busy       <= 1'b1;
`ifdef DIV_SCHED_DZ_EN
            if (win_dvsor == 32'd0) state <= ZERO;
            else                    state <= RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // Divider leaves reset one cycle after the grant; cnt counts
          // only the cycles it has actually been running.
          div_reset <= 1'b0;
          if (!div_reset) cnt <= cnt + 6'd1;
          if (div_fin) begin
            quot_out  <= div_quot;
            rem_out   <= div_rem[63:32];
            ovf       <= ovf_p;
            dz        <= 1'b0;
            err       <= 1'b0;
            done      <= NREQ'(1) << owner;
            div_reset <= 1'b1;
            state     <= DONE;
          end else if (cnt == 6'(WDOG)) begin
            quot_out  <= '0;
            rem_out   <= '0;
            ovf       <= ovf_p;
            dz        <= 1'b0;
            err       <= 1'b1;
            done      <= NREQ'(1) << owner;
            div_reset <= 1'b1;
            state     <= DONE;
          end
        end
`ifdef DIV_SCHED_DZ_EN
        ZERO: begin
          // Two cycles here so the dz result lands two cycles after gnt.
          div_reset <= 1'b1;
          cnt       <= cnt + 6'd1;
          if (cnt[0]) begin
            quot_out <= 32'hFFFF_FFFF;
            rem_out  <= div_dvdend[31:0];
            ovf      <= 1'b0;
            dz       <= 1'b1;
            err      <= 1'b0;
            done     <= NREQ'(1) << owner;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          div_reset <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          div_reset <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized scoreboard bench for div_sched with a
// behavioural divider model attached to the divider port.
module tb_div_sched;
  localparam int NREQ = 4;
  localparam int WDOG = 40;

  typedef struct {
    int          idx;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        ovf;
    logic        dz;
    logic        err;
    int          due;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_s = '0;
  logic [64*NREQ-1:0]  dvdend_in;
  logic [32*NREQ-1:0]  dvsor_in;
  logic [NREQ-1:0]     gnt, done;
  logic [31:0]         quot_out, rem_out;
  logic                ovf, dz, err, busy, div_reset;
  logic [63:0]         div_dvdend;
  logic [31:0]         div_dvsor;
  logic                div_fin;
  logic [31:0]         div_quot;
  logic [63:0]         div_rem;

  logic [63:0] a_dvd [NREQ];
  logic [31:0] a_dvs [NREQ];

  logic [5:0]  rep = '0;
  logic        fin_r = 1'b0;
  logic [31:0] mq = '0, mr = '0;
  logic        stuck = 1'b0;
  logic        hold = 1'b0;

  exp_t sbq[$];
  int   gorder[$];
  int   gcyc [NREQ];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   tb_ptr = NREQ - 1;

  div_sched #(.NREQ(NREQ), .WDOG(WDOG)) dut (
    .clk(clk), .reset(reset), .req(req),
    .dvdend_in(dvdend_in), .dvsor_in(dvsor_in),
    .gnt(gnt), .done(done), .quot_out(quot_out), .rem_out(rem_out),
    .ovf(ovf), .dz(dz), .err(err), .busy(busy),
    .div_reset(div_reset), .div_dvdend(div_dvdend), .div_dvsor(div_dvsor),
    .div_fin(div_fin), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) req_s <= req;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dvdend_in[64*i +: 64] = a_dvd[i];
      dvsor_in[32*i +: 32]  = a_dvs[i];
    end
  end

  // Plain-arithmetic quotient/remainder: {quot[31:0], rem[31:0]}.
  function automatic logic [63:0] divref(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a[63:32]};
    q = a / {32'd0, b};
    r = a % {32'd0, b};
    return {q[31:0], r[31:0]};
  endfunction

  // Divider model: held clear while div_reset, loads on the first free
  // cycle, raises fin after 32 counted steps (or never, when stuck).
  assign div_fin  = fin_r;
  assign div_quot = mq;
  assign div_rem  = {mr, 32'd0};
  always @(posedge clk) begin
    if (div_reset) begin
      rep   <= '0;
      fin_r <= 1'b0;
    end else begin
      if (rep == 6'd0) {mq, mr} <= divref(div_dvdend, div_dvsor);
      rep <= rep + 6'd1;
      if (rep == 6'd31 && !stuck) fin_r <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks grants against a round-robin model, pushes the
  // expected result, and pops/compares whenever done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
        tb_ptr = NREQ - 1;
      end else begin
        if (gnt != '0) begin : gmon
          int   w;
          exp_t e;
          logic [63:0] qr;
          w = -1;
          for (int o = 1; o <= NREQ; o++) begin
            int c;
            c = (tb_ptr + o) % NREQ;
            if (w < 0 && ((req_s >> c) & NREQ'(1)) != '0) w = c;
          end
          if (w < 0) begin
            chk("gnt_unexpected", 64'(gnt), 64'd0);
          end else begin
            chk("gnt_winner", 64'(gnt), 64'(NREQ'(1) << w));
            tb_ptr  = w;
            gorder.push_back(w);
            gcyc[w] = cyc;
            qr      = divref(a_dvd[w], a_dvs[w]);
            e.idx   = w;
            e.quot  = qr[63:32];
            e.rem   = qr[31:0];
            e.ovf   = (a_dvd[w][63:32] >= a_dvs[w]);
            e.dz    = 1'b0;
            e.err   = 1'b0;
            e.due   = cyc + 34;
            if (stuck) begin
              e.quot = '0;
              e.rem  = '0;
              e.err  = 1'b1;
              e.due  = cyc + WDOG + 2;
            end
`ifdef DIV_SCHED_DZ_EN
            if (a_dvs[w] == 32'd0) begin
              e.quot = 32'hFFFF_FFFF;
              e.rem  = a_dvd[w][31:0];
              e.ovf  = 1'b0;
              e.dz   = 1'b1;
              e.err  = 1'b0;
              e.due  = cyc + 2;
            end
`endif
            sbq.push_back(e);
          end
        end
        if (done != '0) begin : dmon
          exp_t e;
          if (sbq.size() == 0) begin
            chk("done_unexpected", 64'(done), 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("done_owner", 64'(done), 64'(NREQ'(1) << e.idx));
            chk("done_cycle", 64'(cyc), 64'(e.due));
            chk("quot_out",   64'(quot_out), 64'(e.quot));
            chk("rem_out",    64'(rem_out),  64'(e.rem));
            chk("ovf",        64'(ovf), 64'(e.ovf));
            chk("dz",         64'(dz),  64'(e.dz));
            chk("err",        64'(err), 64'(e.err));
          end
        end
      end
    end
  end

  // Requesters drop their request on seeing gnt unless holding.
  task automatic tick();
    @(negedge clk);
    #1;
    if (!hold) req = req & ~gnt;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while ((req != '0 || busy || sbq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    nchk++;
    if (n >= budget) begin
      nerr++;
      $display("FAIL %s_drain timed out after %0d cycles, pending=%0d", nm, n, sbq.size());
    end
  endtask

  task automatic single(input int i, input logic [63:0] d, input logic [31:0] s, input string nm);
    a_dvd[i] = d;
    a_dvs[i] = s;
    req = req | (NREQ'(1) << i);
    wait_drain(200, nm);
  endtask

  task automatic rnd_op(output logic [63:0] d, output logic [31:0] s);
    s = $urandom;
    if (s == 32'd0) s = 32'd1;
    if ($urandom_range(0, 3) != 0) d = {$urandom % s, 32'($urandom)};
    else                           d = {32'($urandom), 32'($urandom)};
  endtask

  initial begin : stim
    logic [63:0] d;
    logic [31:0] s;
    int          ord [5];
    int          n;
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      a_dvd[i] = '0;
      a_dvs[i] = 32'd1;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_gnt",    64'(gnt), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_quot",   64'(quot_out), 64'd0);
    chk("rst_rem",    64'(rem_out), 64'd0);
    chk("rst_ovf",    64'(ovf), 64'd0);
    chk("rst_dz",     64'(dz), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_divrst", 64'(div_reset), 64'd1);
    chk("rst_dvdend", div_dvdend, 64'd0);
    chk("rst_dvsor",  64'(div_dvsor), 64'd0);
    reset = 1'b0;

    // Single request 7/2
    single(0, 64'd7, 32'd2, "t1");
    chk("t1_quot", 64'(quot_out), 64'd3);
    chk("t1_rem",  64'(rem_out), 64'd1);

    // Move pointer to 3 so requester 0 is next in line
    rnd_op(d, s);
    single(3, d, s, "p3a");

    // Simultaneous requests 0 and 2
    a_dvd[0] = 64'd100; a_dvs[0] = 32'd7;
    a_dvd[2] = 64'd50;  a_dvs[2] = 32'd3;
    req = 4'b0101;
    wait_drain(300, "t2");
    chk("t2_gnt_spacing", 64'(gcyc[2] - gcyc[0]), 64'd36);
    chk("t2_quot", 64'(quot_out), 64'd16);
    chk("t2_rem",  64'(rem_out), 64'd2);

    rnd_op(d, s);
    single(3, d, s, "p3b");

    // Round-robin with all requesters held
    for (int i = 0; i < NREQ; i++) begin
      rnd_op(d, s);
      a_dvd[i] = d;
      a_dvs[i] = s;
    end
    gorder.delete();
    hold = 1'b1;
    req  = '1;
    n    = 0;
    while (gorder.size() < 5 && n < 400) begin
      tick();
      n++;
    end
    req  = '0;
    hold = 1'b0;
    chk("rr_count", 64'(gorder.size() >= 5), 64'd1);
    if (gorder.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(gorder[i]), 64'(ord[i]));
    wait_drain(300, "rr");

    // Quotient overflow
    single(1, 64'h0000_0005_0000_0000, 32'd5, "ovf");
    chk("ovf_flag", 64'(ovf), 64'd1);

`ifdef DIV_SCHED_DZ_EN
    single(0, 64'd9, 32'd0, "dz");
    chk("dz_quot", 64'(quot_out), 64'hFFFF_FFFF);
    chk("dz_rem",  64'(rem_out), 64'd9);
    chk("dz_flag", 64'(dz), 64'd1);
`endif

    // Watchdog abort
    stuck = 1'b1;
    rnd_op(d, s);
    single(2, d, s, "wdog");
    stuck = 1'b0;
    chk("wdog_err",  64'(err), 64'd1);
    chk("wdog_quot", 64'(quot_out), 64'd0);

    // Random traffic
    n = 0;
    for (int issued = 0; issued < 16 && n < 3000; n++) begin
      int i;
      tick();
      if ($urandom_range(0, 7) == 0) begin
        i = $urandom_range(0, NREQ - 1);
        if (((req >> i) & NREQ'(1)) == '0) begin
          rnd_op(d, s);
          a_dvd[i] = d;
          a_dvs[i] = s;
          req = req | (NREQ'(1) << i);
          issued++;
        end
      end
    end
    wait_drain(1500, "rand");

    // Reset in the middle of an operation
    rnd_op(d, s);
    a_dvd[0] = d;
    a_dvs[0] = s;
    req = 4'b0001;
    n = 0;
    while (gnt[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_gnt_seen", 64'(gnt[0]), 64'd1);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("mid_divrst", 64'(div_reset), 64'd1);
    chk("mid_busy",   64'(busy), 64'd0);
    chk("mid_done",   64'(done), 64'd0);
    rnd_op(d, s);
    a_dvd[1] = d;
    a_dvs[1] = s;
    req   = 4'b0010;
    reset = 1'b0;
    tick();
    chk("post_rst_gnt", 64'(gnt), 64'd2);
    wait_drain(300, "post_rst");
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
